// File: rtl/sumnb_seg.sv
// sumnb_seg: W-bit pipelined adder/subtractor. The carry chain is cut into S = W/K
// registered K-bit segments; operands are skewed in, the sum deskewed out.
module sumnb_seg #(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] so,
    output logic         co,
    output logic         ov,
    output logic         z,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int S = W / K;

    logic                adv;
    logic [S-1:0][W-1:0] a_q, a_d, be_q, be_d, sum_q, sum_d;
    logic [S-1:0]        c_q, c_d, cin, vld_q, vld_d;
    logic [S-1:0][K:0]   seg;
    logic                ov_q, ov_d, z_q, z_d;
    logic                unused_q;

    // One global enable: the whole pipe either shifts or freezes, bubbles included.
    assign adv = ~vld_q[S-1] | out_ready;

    always_comb begin
        a_d   = '0;
        be_d  = '0;
        sum_d = '0;
        vld_d = '0;
        cin   = '0;
        c_d   = '0;
        seg   = '0;
        a_d[0]   = a;
        be_d[0]  = b ^ {W{sub}};
        vld_d[0] = in_valid;
        cin[0]   = ci ^ sub;
        for (int i = 1; i < S; i++) begin
            a_d[i]   = a_q[i-1];
            be_d[i]  = be_q[i-1];
            sum_d[i] = sum_q[i-1];
            vld_d[i] = vld_q[i-1];
            cin[i]   = c_q[i-1];
        end
        // Stage i resolves only its own segment; lower segments ride along already done.
        for (int i = 0; i < S; i++) begin
            seg[i] = {1'b0, a_d[i][i*K +: K]} + {1'b0, be_d[i][i*K +: K]} + {{K{1'b0}}, cin[i]};
            sum_d[i][i*K +: K] = seg[i][K-1:0];
            c_d[i] = seg[i][K];
        end
        ov_d = (a_d[S-1][W-1] == be_d[S-1][W-1]) && (sum_d[S-1][W-1] != a_d[S-1][W-1]);
        z_d  = ~|sum_d[S-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            be_q  <= '0;
            sum_q <= '0;
            c_q   <= '0;
            vld_q <= '0;
            ov_q  <= 1'b0;
            z_q   <= 1'b0;
        end else if (adv) begin
            a_q   <= a_d;
            be_q  <= be_d;
            sum_q <= sum_d;
            c_q   <= c_d;
            vld_q <= vld_d;
            ov_q  <= ov_d;
            z_q   <= z_d;
        end
    end

    // Last-stage operand copies are never consumed; flags are formed one stage earlier.
    assign unused_q  = ^{a_q[S-1], be_q[S-1]};

    assign in_ready  = adv;
    assign so        = sum_q[S-1];
    assign co        = c_q[S-1];
    assign ov        = ov_q;
    assign z         = z_q;
    assign out_valid = vld_q[S-1];
endmodule

// File: tb/tb_sumnb_seg.sv
// Scoreboard bench for sumnb_seg: W16/K4 main instance plus W8/K8 and W32/K8 sweep instances.
`timescale 1ns/1ps
module tb_sumnb_seg;
    typedef struct {
        logic [31:0] so;
        logic        co;
        logic        ov;
        logic        z;
        logic        lat_chk;
        time         t_acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [15:0] a = '0, b = '0, so;
    logic        ci = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, co, ov, z, out_valid;

    logic [7:0]  a8 = '0, b8 = '0, so8;
    logic [31:0] a32 = '0, b32 = '0, so32;
    logic        ci_s = 1'b0, sub_s = 1'b0, vld_s = 1'b0;
    logic        rdy8, co8, ov8, z8, ov_v8;
    logic        rdy32, co32, ov32, z32, ov_v32;

    exp_t q16[$], q8[$], q32[$];
    exp_t e16, e8, e32;
    int   n_chk = 0, n_err = 0, n_sent = 0, n_out = 0, cyc = 0;
    logic rand_ready = 1'b0, to_flag = 1'b0, done_req = 1'b0;
    logic prev_rst = 1'b1, held_v = 1'b0, to_seen = 1'b0;
    logic [18:0] held_out;

    always #5 clk = ~clk;

    sumnb_seg #(.W(16), .K(4)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .so(so), .co(co), .ov(ov), .z(z),
        .out_valid(out_valid), .out_ready(out_ready)
    );
    sumnb_seg #(.W(8), .K(8)) u_s1 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci_s), .sub(sub_s),
        .in_valid(vld_s), .in_ready(rdy8), .so(so8), .co(co8), .ov(ov8), .z(z8),
        .out_valid(ov_v8), .out_ready(1'b1)
    );
    sumnb_seg #(.W(32), .K(8)) u_w32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .ci(ci_s), .sub(sub_s),
        .in_valid(vld_s), .in_ready(rdy32), .so(so32), .co(co32), .ov(ov32), .z(z32),
        .out_valid(ov_v32), .out_ready(1'b1)
    );

    // Whole-word reference: one wide add, no segmentation.
    function automatic exp_t ref_res(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                     input logic tci, input logic tsub);
        exp_t r;
        logic [32:0] m, be, s;
        m  = (33'd1 << w) - 33'd1;
        be = {1'b0, tb ^ {32{tsub}}} & m;
        s  = ({1'b0, ta} & m) + be + {32'd0, tci ^ tsub};
        r.so = s[31:0] & m[31:0];
        r.co = s[w];
        r.ov = (ta[w-1] == be[w-1]) && (r.so[w-1] != ta[w-1]);
        r.z  = (r.so == 32'd0);
        r.lat_chk = 1'b0;
        r.t_acc   = 0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] tso, input logic tco, input logic tov, input logic tz);
        exp_t r;
        r.so = tso; r.co = tco; r.ov = tov; r.z = tz; r.lat_chk = 1'b0; r.t_acc = 0;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                        input logic tsub, input exp_t e);
        int  n = 0;
        bit  done = 0;
        a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.t_acc = $time;
                q16.push_back(e);
                n_sent++;
                done = 1;
            end else if (++n > 500) begin
                to_flag = 1'b1;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_sw(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                           input logic tsub, input exp_t x8, input exp_t x32);
        a8 = ta[7:0]; b8 = tb[7:0]; a32 = ta; b32 = tb; ci_s = tci; sub_s = tsub; vld_s = 1'b1;
        @(negedge clk);
        x8.t_acc = $time; x32.t_acc = $time;
        if (rdy8)  q8.push_back(x8);
        if (rdy32) q32.push_back(x32);
        @(posedge clk); #1;
        vld_s = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((q16.size() + q8.size() + q32.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) to_flag = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e, f;
        logic [15:0] ra, rb;
        logic        rc, rs;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, hand-computed.
        e = mk(32'h0000, 1'b1, 1'b0, 1'b1); e.lat_chk = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, e);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(32'hFFFE, 1'b0, 1'b0, 1'b0));
        send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(32'hFFFD, 1'b0, 1'b0, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1, 1'b0));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(32'h7FFF, 1'b1, 1'b1, 1'b0));
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0, mk(32'h2234, 1'b0, 1'b0, 1'b0));
        send(16'h1234, 16'h1234, 1'b0, 1'b1, mk(32'h0000, 1'b1, 1'b0, 1'b1));
        wait_empty();

        // Streaming under random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, ref_res(16, {16'h0, ra}, {16'h0, rb}, rc, rs));
        end
        wait_empty();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with three transactions in flight; they must never emerge.
        for (int i = 0; i < 3; i++)
            send(16'(i + 1), 16'h0100, 1'b0, 1'b0, ref_res(16, 32'(i + 1), 32'h0100, 1'b0, 1'b0));
        rst = 1'b1;
        n_sent -= q16.size();
        q16.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        e = mk(32'h4321, 1'b0, 1'b0, 1'b0); e.lat_chk = 1'b1;
        send(16'h4000, 16'h0321, 1'b0, 1'b0, e);
        wait_empty();

        // Parameter sweep: S=1 and W=32/S=4.
        e = mk(32'h7F, 1'b1, 1'b1, 1'b0);       e.lat_chk = 1'b1;
        f = mk(32'h7F, 1'b1, 1'b0, 1'b0);       f.lat_chk = 1'b1;
        send_sw(32'h80, 32'h01, 1'b0, 1'b1, e, f);
        wait_empty();
        send_sw(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h00, 1'b1, 1'b0, 1'b1), mk(32'h0, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 24; i++) begin
            logic [31:0] sa, sb;
            logic        sc, ss;
            sa = $urandom; sb = $urandom; sc = 1'($urandom); ss = 1'($urandom);
            send_sw(sa, sb, sc, ss, ref_res(8, sa, sb, sc, ss), ref_res(32, sa, sb, sc, ss));
        end
        wait_empty();
        done_req = 1'b1;
    end

    // Monitor: the only process that counts checks and errors.
    always @(negedge clk) begin
        cyc++;
        if (cyc > 20000) begin
            n_chk++; n_err++;
            $display("FAIL watchdog: got cyc=%0d required done before 20000", cyc);
            $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
            $finish;
        end
        if (to_flag && !to_seen) begin
            to_seen = 1'b1; n_chk++; n_err++;
            $display("FAIL handshake_timeout: got no progress required progress at t=%0t", $time);
        end
        if (!rst && prev_rst) begin
            n_chk++;
            if ({out_valid, so, co, ov, z, in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1}) begin
                n_err++;
                $display("FAIL reset_state: got v=%b so=%h co=%b ov=%b z=%b rdy=%b required 0 0000 0 0 0 1",
                         out_valid, so, co, ov, z, in_ready);
            end
            n_chk++;
            if ({ov_v8, ov_v32, rdy8, rdy32} !== 4'b0011) begin
                n_err++;
                $display("FAIL reset_sweep: got v8=%b v32=%b r8=%b r32=%b required 0 0 1 1",
                         ov_v8, ov_v32, rdy8, rdy32);
            end
        end
        if (!rst) begin
            n_chk++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_err++;
                $display("FAIL in_ready: got %b required %b", in_ready, !out_valid || out_ready);
            end
            if (held_v) begin
                n_chk++;
                if ({out_valid, so, co, ov, z} !== {1'b1, held_out}) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b so=%h co=%b ov=%b z=%b required v=1 %h",
                             out_valid, so, co, ov, z, held_out);
                end
            end
            if (out_valid && out_ready) begin
                n_chk++; n_out++;
                if (q16.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out16: got so=%h required no output", so);
                end else begin
                    e16 = q16.pop_front();
                    if ({so, co, ov, z} !== {e16.so[15:0], e16.co, e16.ov, e16.z}) begin
                        n_err++;
                        $display("FAIL result16: got so=%h co=%b ov=%b z=%b required so=%h co=%b ov=%b z=%b",
                                 so, co, ov, z, e16.so[15:0], e16.co, e16.ov, e16.z);
                    end
                    if (e16.lat_chk) begin
                        n_chk++;
                        if ($time - e16.t_acc != 40) begin
                            n_err++;
                            $display("FAIL latency16: got %0t required 40", $time - e16.t_acc);
                        end
                    end
                end
            end
            if (ov_v8) begin
                n_chk++;
                if (q8.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out8: got so=%h required no output", so8);
                end else begin
                    e8 = q8.pop_front();
                    if ({so8, co8, ov8, z8} !== {e8.so[7:0], e8.co, e8.ov, e8.z}) begin
                        n_err++;
                        $display("FAIL result8: got so=%h co=%b ov=%b z=%b required so=%h co=%b ov=%b z=%b",
                                 so8, co8, ov8, z8, e8.so[7:0], e8.co, e8.ov, e8.z);
                    end
                    if (e8.lat_chk) begin
                        n_chk++;
                        if ($time - e8.t_acc != 10) begin
                            n_err++;
                            $display("FAIL latency8: got %0t required 10", $time - e8.t_acc);
                        end
                    end
                end
            end
            if (ov_v32) begin
                n_chk++;
                if (q32.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out32: got so=%h required no output", so32);
                end else begin
                    e32 = q32.pop_front();
                    if ({so32, co32, ov32, z32} !== {e32.so, e32.co, e32.ov, e32.z}) begin
                        n_err++;
                        $display("FAIL result32: got so=%h co=%b ov=%b z=%b required so=%h co=%b ov=%b z=%b",
                                 so32, co32, ov32, z32, e32.so, e32.co, e32.ov, e32.z);
                    end
                    if (e32.lat_chk) begin
                        n_chk++;
                        if ($time - e32.t_acc != 40) begin
                            n_err++;
                            $display("FAIL latency32: got %0t required 40", $time - e32.t_acc);
                        end
                    end
                end
            end
        end
        held_v   = !rst && out_valid && !out_ready;
        held_out = {so, co, ov, z};
        prev_rst = rst;
        if (done_req) begin
            n_chk++;
            if (n_out != n_sent || q16.size() != 0) begin
                n_err++;
                $display("FAIL count16: got out=%0d pending=%0d required out=%0d pending=0",
                         n_out, q16.size(), n_sent);
            end
            n_chk++;
            if (q8.size() != 0 || q32.size() != 0) begin
                n_err++;
                $display("FAIL count_sweep: got pending8=%0d pending32=%0d required 0 0",
                         q8.size(), q32.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
            $finish;
        end
    end
endmodule

// File: doc/sumnb_seg.md
# sumnb_seg

Parametrised, pipelined N-bit adder/subtractor for the arithmetic datapath. It generalises the 4-bit ripple adder to any width W and splits the carry chain into W/K segments of K bits, one register stage per segment, so the clock rate is set by a K-bit carry chain rather than the full W-bit chain. It adds a subtract mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure. It is used wherever wide sums must close timing at full system clock.

## Interface
- W, 16: operand and result width; must be a multiple of K and ≥ K.
- K, 4: segment width (bits resolved per stage); number of stages S = W/K.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  W  operand A (unsigned or two's complement).
- b  in  W  operand B.
- ci  in  1  carry-in (add) / borrow-in (subtract, see Operation).
- sub  in  1  mode: 0 = add, 1 = subtract.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept this cycle.
- so  out  W  result.
- co  out  1  carry-out of MSB (subtract: 1 = no borrow).
- ov  out  1  signed overflow.
- z  out  1  result equals zero.
- out_valid  out  1  so/co/ov/z valid.
- out_ready  in  1  consumer accepts result.

## Operation
- Effective operands: b_e = b XOR {W{sub}}, c0 = ci XOR sub. Result {co, so} = a + b_e + c0.
  - sub=0, ci=0: a+b. sub=0, ci=1: a+b+1. sub=1, ci=0: a−b. sub=1, ci=1: a−b−1.
- Stage i (0..S−1) adds bits [iK+K−1 : iK] of a and b_e with the carry registered from stage i−1 (stage 0 uses c0), and registers the K-bit partial sum and carry.
- Operand skew: bits of segment i are delayed i register stages before entering stage i. Result deskew: partial sum of segment i is delayed S−1−i stages so all W bits reach the output register together.
- mode and operands of one transaction travel together; transactions never mix.
- Flags on the output word: co = carry out of stage S−1; ov = (a[W−1] == b_e[W−1]) AND (so[W−1] != a[W−1]), with a[W−1]/b_e[W−1] carried down the pipe; z = (so == 0).
- Handshake: advance = NOT out_valid OR out_ready. in_ready = advance. A transfer on input occurs when in_valid AND in_ready; on output when out_valid AND out_ready.
- Global stall: when advance = 0 every stage register, including valid bits, holds. Bubbles are not compressed.
- Per-stage valid bit shifts with the data. A bubble (in_valid=0 on an advance) propagates as invalid.

## Timing
- Reset: all valid bits 0; out_valid=0, so=0, co=0, ov=0, z=0, in_ready=1 in the cycle after reset is released (in_ready follows advance, which is 1 because out_valid=0).
- Latency: a transaction accepted at edge t is on the outputs with out_valid=1 after edge t+S when there is no stall. Each stall cycle adds one cycle.
- Throughput: one transaction per cycle while out_ready=1.
- Output data is stable while out_valid=1 and out_ready=0.
- rst asserted mid-operation: all in-flight transactions are discarded and outputs return to reset values on the next edge. rst has priority over the handshake.
- S=1 (K=W): single registered adder, latency 1 cycle.
- Wrap-around: so is modulo 2^W. Overflow is reported only through co/ov.

## Test plan
- W=16, K=4, add, a=0xFFFF, b=0x0001, ci=0 → 4 cycles later so=0x0000, co=1, ov=0, z=1.
- Subtract, a=0x0005, b=0x0007, ci=0 → so=0xFFFE, co=0 (borrow), ov=0, z=0. Repeat with ci=1 → so=0xFFFD.
- Signed overflow: add a=0x7FFF, b=0x0001 → so=0x8000, co=0, ov=1. Subtract a=0x8000, b=0x0001 → so=0x7FFF, co=1, ov=1.
- Streaming: 64 random back-to-back transactions with out_ready toggled pseudo-randomly. Checks:
  - results match a scoreboard in order;
  - nothing is lost or duplicated;
  - so is held while stalled;
  - in_ready equals NOT out_valid OR out_ready.
- Reset mid-stream: rst asserted for 1 cycle with 3 transactions in flight → out_valid=0 and all outputs are 0 on the next edge. None of the 3 transactions ever appear. The next accepted transaction emerges S cycles later.
- Parameter sweep: W=8/K=8 (S=1, latency 1) and W=32/K=8 (S=4) with random add/sub vectors checked against a reference model.
